// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file writeback arbiter for LD/ALU/MD (optional bypass: WB_FWD_EN)
module regfile_wb_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int WCNT_W   = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ld_req,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        ld_ack,
   input  logic        alu_req,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ack,
   input  logic        md_req,
   input  logic [4:0]  md_rd,
   input  logic [31:0] md_data,
   output logic        md_ack,
   output logic        we,
   output logic [4:0]  waddr,
   output logic [31:0] wdata,
   output logic        conflict
`ifdef WB_FWD_EN
   ,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   output logic        fwd_rs_hit,
   output logic        fwd_rt_hit,
   output logic [31:0] fwd_rs_data,
   output logic [31:0] fwd_rt_data
`endif
);

   localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);

   logic [WCNT_W-1:0] ld_wcnt, alu_wcnt, md_wcnt;
   logic pend_ld, pend_alu, pend_md;
   logic starv_ld, starv_alu, starv_md;
   logic gnt_ld, gnt_alu, gnt_md;
   logic any_gnt, multi_pend;

   // Writes to r0 are discarded, so only nonzero destinations compete for the port.
   assign pend_ld  = ld_req  && (ld_rd  != 5'd0);
   assign pend_alu = alu_req && (alu_rd != 5'd0);
   assign pend_md  = md_req  && (md_rd  != 5'd0);

   assign starv_ld  = pend_ld  && (ld_wcnt  == WAIT_MAX);
   assign starv_alu = pend_alu && (alu_wcnt == WAIT_MAX);
   assign starv_md  = pend_md  && (md_wcnt  == WAIT_MAX);

   assign multi_pend = (pend_ld && pend_alu) || (pend_ld && pend_md) || (pend_alu && pend_md);
   assign any_gnt    = gnt_ld || gnt_alu || gnt_md;

   // Pick one winner: starved sources first, then LD > ALU > MD within each class.
   always_comb begin
      gnt_ld  = 1'b0;
      gnt_alu = 1'b0;
      gnt_md  = 1'b0;
      if (starv_ld)       gnt_ld  = 1'b1;
      else if (starv_alu) gnt_alu = 1'b1;
      else if (starv_md)  gnt_md  = 1'b1;
      else if (pend_ld)   gnt_ld  = 1'b1;
      else if (pend_alu)  gnt_alu = 1'b1;
      else if (pend_md)   gnt_md  = 1'b1;
   end

   // r0 requests are acknowledged immediately alongside whichever source wins the port.
   always_comb begin
      ld_ack  = RST && (gnt_ld  || (ld_req  && (ld_rd  == 5'd0)));
      alu_ack = RST && (gnt_alu || (alu_req && (alu_rd == 5'd0)));
      md_ack  = RST && (gnt_md  || (md_req  && (md_rd  == 5'd0)));
   end

   function automatic logic [WCNT_W-1:0] next_wcnt(input logic [WCNT_W-1:0] cnt,
                                                  input logic req, input logic ack);
      if (!req || ack)
         return '0;
      else if (cnt == WAIT_MAX)
         return cnt;
      else
         return cnt + WCNT_W'(1);
   endfunction

   // Count consecutive denied cycles per source, saturating at the starvation threshold.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         ld_wcnt  <= '0;
         alu_wcnt <= '0;
         md_wcnt  <= '0;
      end else begin
         ld_wcnt  <= next_wcnt(ld_wcnt,  ld_req,  ld_ack);
         alu_wcnt <= next_wcnt(alu_wcnt, alu_req, alu_ack);
         md_wcnt  <= next_wcnt(md_wcnt,  md_req,  md_ack);
      end
   end

   // Registered write port; address and data hold when nothing is granted.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         we       <= 1'b0;
         waddr    <= 5'd0;
         wdata    <= 32'd0;
         conflict <= 1'b0;
      end else begin
         we       <= any_gnt;
         conflict <= multi_pend;
         if (gnt_ld) begin
            waddr <= ld_rd;
            wdata <= ld_data;
         end else if (gnt_alu) begin
            waddr <= alu_rd;
            wdata <= alu_data;
         end else if (gnt_md) begin
            waddr <= md_rd;
            wdata <= md_data;
         end
      end
   end

`ifdef WB_FWD_EN
   // Bypass the write landing this cycle to decode's source operands.
   always_comb begin
      fwd_rs_hit  = we && (waddr == rs_addr) && (rs_addr != 5'd0);
      fwd_rt_hit  = we && (waddr == rt_addr) && (rt_addr != 5'd0);
      fwd_rs_data = fwd_rs_hit ? wdata : 32'd0;
      fwd_rt_data = fwd_rt_hit ? wdata : 32'd0;
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   localparam int MAX_WAIT = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ld_req, alu_req, md_req;
   logic [4:0]  ld_rd, alu_rd, md_rd;
   logic [31:0] ld_data, alu_data, md_data;
   logic        ld_ack, alu_ack, md_ack;
   logic        we, conflict;
   logic [4:0]  waddr;
   logic [31:0] wdata;
`ifdef WB_FWD_EN
   logic [4:0]  rs_addr, rt_addr;
   logic        fwd_rs_hit, fwd_rt_hit;
   logic [31:0] fwd_rs_data, fwd_rt_data;
`endif

   int total = 0;
   int bad   = 0;

   // reference model state: expected registered outputs for the current cycle
   int          m_wait [3];
   logic        m_we, m_conf;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   bit          m_valid = 1'b0;

   regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .WCNT_W(3)) dut (
      .CLK(CLK), .RST(RST),
      .ld_req(ld_req), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ack(ld_ack),
      .alu_req(alu_req), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ack(alu_ack),
      .md_req(md_req), .md_rd(md_rd), .md_data(md_data), .md_ack(md_ack),
      .we(we), .waddr(waddr), .wdata(wdata), .conflict(conflict)
`ifdef WB_FWD_EN
      , .rs_addr(rs_addr), .rt_addr(rt_addr),
      .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
      .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Model: sees the same inputs the DUT latches at the next rising edge.
   always @(negedge CLK) begin : model_cmp
      logic        r [3];
      logic [4:0]  rd [3];
      logic [31:0] dt [3];
      logic        e_ack [3];
      logic        act_ack [3];
      int          g, npend;
      r[0] = ld_req;  rd[0] = ld_rd;  dt[0] = ld_data;  act_ack[0] = ld_ack;
      r[1] = alu_req; rd[1] = alu_rd; dt[1] = alu_data; act_ack[1] = alu_ack;
      r[2] = md_req;  rd[2] = md_rd;  dt[2] = md_data;  act_ack[2] = md_ack;
      g = -1;
      npend = 0;
      for (int i = 0; i < 3; i++)
         if (r[i] && rd[i] != 0) npend++;
      for (int i = 2; i >= 0; i--)
         if (r[i] && rd[i] != 0 && m_wait[i] == MAX_WAIT) g = i;
      if (g < 0)
         for (int i = 2; i >= 0; i--)
            if (r[i] && rd[i] != 0) g = i;
      for (int i = 0; i < 3; i++) begin
         e_ack[i] = RST && ((i == g) || (r[i] && rd[i] == 0));
         chk($sformatf("model_ack%0d", i), {31'd0, act_ack[i]}, {31'd0, e_ack[i]});
      end
      if (m_valid) begin
         chk("model_we", {31'd0, we}, {31'd0, m_we});
         chk("model_waddr", {27'd0, waddr}, {27'd0, m_waddr});
         chk("model_wdata", wdata, m_wdata);
         chk("model_conflict", {31'd0, conflict}, {31'd0, m_conf});
         if (we === 1'b1 && waddr === 5'd0)
            chk("no_write_r0", {27'd0, waddr}, 32'd1);
`ifdef WB_FWD_EN
         chk("model_rs_hit", {31'd0, fwd_rs_hit}, {31'd0, m_we && m_waddr == rs_addr && rs_addr != 0});
         chk("model_rs_data", fwd_rs_data, (m_we && m_waddr == rs_addr && rs_addr != 0) ? m_wdata : 32'd0);
         chk("model_rt_hit", {31'd0, fwd_rt_hit}, {31'd0, m_we && m_waddr == rt_addr && rt_addr != 0});
         chk("model_rt_data", fwd_rt_data, (m_we && m_waddr == rt_addr && rt_addr != 0) ? m_wdata : 32'd0);
`endif
      end
      if (!RST) begin
         m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_conf = 1'b0;
         for (int i = 0; i < 3; i++) m_wait[i] = 0;
         m_valid = 1'b1;
      end else begin
         m_we   = (g >= 0);
         m_conf = (npend >= 2);
         if (g >= 0) begin
            m_waddr = rd[g];
            m_wdata = dt[g];
         end
         for (int i = 0; i < 3; i++)
            if (!r[i] || e_ack[i]) m_wait[i] = 0;
            else if (m_wait[i] < MAX_WAIT) m_wait[i]++;
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      RST = 1'b0;
      ld_req = 1'b1;  ld_rd = 5'd1;  ld_data = 32'h101;
      alu_req = 1'b1; alu_rd = 5'd2; alu_data = 32'h202;
      md_req = 1'b1;  md_rd = 5'd3;  md_data = 32'h303;
`ifdef WB_FWD_EN
      rs_addr = 5'd0; rt_addr = 5'd0;
`endif
      // reset with all requests up
      @(negedge CLK);
      chk("rst_ld_ack", {31'd0, ld_ack}, 32'd0);
      tick();
      @(negedge CLK);
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_waddr", {27'd0, waddr}, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_conflict", {31'd0, conflict}, 32'd0);
      chk("rst_md_ack", {31'd0, md_ack}, 32'd0);
      tick();
      RST = 1'b1;
      @(negedge CLK);
      chk("rel_ld_ack", {31'd0, ld_ack}, 32'd1);
      chk("rel_alu_ack", {31'd0, alu_ack}, 32'd0);
      tick(); ld_req = 1'b0;
      @(negedge CLK);
      chk("rel_alu_ack2", {31'd0, alu_ack}, 32'd1);
      tick(); alu_req = 1'b0;
      @(negedge CLK);
      chk("rel_md_ack", {31'd0, md_ack}, 32'd1);
      tick(); md_req = 1'b0;
      tick();

      // single ALU write
      alu_req = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
      @(negedge CLK);
      chk("single_ack", {31'd0, alu_ack}, 32'd1);
      tick(); alu_req = 1'b0;
      @(negedge CLK);
      chk("single_we", {31'd0, we}, 32'd1);
      chk("single_waddr", {27'd0, waddr}, 32'd5);
      chk("single_wdata", wdata, 32'hAA);
      tick();
      @(negedge CLK);
      chk("single_we_off", {31'd0, we}, 32'd0);
      chk("single_waddr_hold", {27'd0, waddr}, 32'd5);
      tick();

      // priority and conflict
      ld_req = 1'b1;  ld_rd = 5'd3;  ld_data = 32'h11;
      alu_req = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
      md_req = 1'b1;  md_rd = 5'd6;  md_data = 32'h33;
      @(negedge CLK);
      chk("pri_ld_ack", {31'd0, ld_ack}, 32'd1);
      chk("pri_alu_ack0", {31'd0, alu_ack}, 32'd0);
      tick(); ld_req = 1'b0;
      @(negedge CLK);
      chk("pri_alu_ack", {31'd0, alu_ack}, 32'd1);
      chk("pri_waddr1", {27'd0, waddr}, 32'd3);
      chk("pri_conf1", {31'd0, conflict}, 32'd1);
      tick(); alu_req = 1'b0;
      @(negedge CLK);
      chk("pri_md_ack", {31'd0, md_ack}, 32'd1);
      chk("pri_waddr2", {27'd0, waddr}, 32'd4);
      chk("pri_conf2", {31'd0, conflict}, 32'd1);
      tick(); md_req = 1'b0;
      @(negedge CLK);
      chk("pri_waddr3", {27'd0, waddr}, 32'd6);
      chk("pri_wdata3", wdata, 32'h33);
      chk("pri_conf3", {31'd0, conflict}, 32'd0);
      tick();

      // starvation: LD streams, MD held
      md_req = 1'b1; md_rd = 5'd9; md_data = 32'h99;
      for (int i = 0; i < 4; i++) begin
         ld_req = 1'b1; ld_rd = 5'(10 + i); ld_data = 32'h1000 + i;
         @(negedge CLK);
         chk($sformatf("stv_ld_ack%0d", i), {31'd0, ld_ack}, 32'd1);
         chk($sformatf("stv_md_wait%0d", i), {31'd0, md_ack}, 32'd0);
         tick();
      end
      ld_rd = 5'd14; ld_data = 32'h1004;
      @(negedge CLK);
      chk("stv_md_ack", {31'd0, md_ack}, 32'd1);
      chk("stv_ld_denied", {31'd0, ld_ack}, 32'd0);
      tick(); md_req = 1'b0;
      @(negedge CLK);
      chk("stv_waddr", {27'd0, waddr}, 32'd9);
      chk("stv_wdata", wdata, 32'h99);
      chk("stv_ld_ack_after", {31'd0, ld_ack}, 32'd1);
      tick(); ld_req = 1'b0;
      @(negedge CLK);
      chk("stv_ld_waddr", {27'd0, waddr}, 32'd14);
      tick();

      // rd==0 in parallel with a real grant
      alu_req = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
      ld_req = 1'b1;  ld_rd = 5'd7;  ld_data = 32'h77;
      @(negedge CLK);
      chk("zero_alu_ack", {31'd0, alu_ack}, 32'd1);
      chk("zero_ld_ack", {31'd0, ld_ack}, 32'd1);
      tick(); alu_req = 1'b0; ld_req = 1'b0;
      @(negedge CLK);
      chk("zero_waddr", {27'd0, waddr}, 32'd7);
      chk("zero_wdata", wdata, 32'h77);
      tick();
      @(negedge CLK);
      chk("zero_we_off", {31'd0, we}, 32'd0);
      tick();

      // reset during a grant discards the write
      alu_req = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020;
      RST = 1'b0;
      @(negedge CLK);
      chk("midrst_ack", {31'd0, alu_ack}, 32'd0);
      tick(); RST = 1'b1; alu_req = 1'b0;
      @(negedge CLK);
      chk("midrst_we", {31'd0, we}, 32'd0);
      chk("midrst_waddr", {27'd0, waddr}, 32'd0);
      tick();

`ifdef WB_FWD_EN
      alu_req = 1'b1; alu_rd = 5'd12; alu_data = 32'hDEAD_BEEF;
      @(negedge CLK);
      tick(); alu_req = 1'b0; rs_addr = 5'd12; rt_addr = 5'd0;
      @(negedge CLK);
      chk("fwd_rs_hit", {31'd0, fwd_rs_hit}, 32'd1);
      chk("fwd_rs_data", fwd_rs_data, 32'hDEAD_BEEF);
      chk("fwd_rt_hit", {31'd0, fwd_rt_hit}, 32'd0);
      chk("fwd_rt_data", fwd_rt_data, 32'd0);
      tick();
      @(negedge CLK);
      chk("fwd_rs_gone", {31'd0, fwd_rs_hit}, 32'd0);
      tick();
`endif

      tick(); tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between three writeback sources: load unit (LD), ALU, and multiply/divide unit (MD, HI/LO results routed via MFHI/MFLO).
- Sits between EX/MEM and the 32x32 register file in the decode stage.
- Each source uses a req/ack handshake. Arbitration is fixed-priority with starvation promotion. The write port is registered.

Parameters:
- MAX_WAIT, 4: number of consecutive denied cycles after which a requester is promoted to starved.
- WCNT_W, 3: width of each wait counter. Must hold MAX_WAIT.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-low.
- ld_req  in  1  LD writeback request.
- ld_rd  in  5  LD destination register.
- ld_data  in  32  LD write data.
- ld_ack  out  1  LD request accepted this cycle (combinational).
- alu_req  in  1  ALU writeback request.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU write data.
- alu_ack  out  1  ALU request accepted (combinational).
- md_req  in  1  MD writeback request.
- md_rd  in  5  MD destination register.
- md_data  in  32  MD write data.
- md_ack  out  1  MD request accepted (combinational).
- we  out  1  register-file write enable (registered).
- waddr  out  5  register-file write address (registered).
- wdata  out  32  register-file write data (registered).
- conflict  out  1  registered; 1 when two or more rd!=0 requests were pending in the previous cycle.

Behaviour:
- Reset (RST==0 at a rising edge):
  - we=0, waddr=0, wdata=0, conflict=0; all wait counters cleared.
  - ack outputs are forced to 0 while RST==0.
  - Reset mid-handshake discards any pending or just-granted write; no we follows.
- Handshake:
  - A source holds req, rd and data stable until it samples ack=1 at a rising edge.
  - After ack, the source may drop req or present a new request in the next cycle.
- rd==0 requests:
  - Acked in the same cycle they are asserted.
  - They never take part in arbitration and never produce we.
  - They may be acked in parallel with a granted source.
- Arbitration (combinational over pending rd!=0 requests):
  - A source is starved when its wait counter equals MAX_WAIT.
  - Starved sources outrank non-starved ones.
  - Within each class the order is LD > ALU > MD.
  - Exactly one rd!=0 request is acked per cycle.
- Write-port latency:
  - A grant in cycle N gives we=1, waddr=rd and wdata=data in cycle N+1.
  - With no grant, we=0 in the next cycle; waddr and wdata hold their previous values.
- Wait counters, one per source:
  - Increment when req && rd!=0 && !ack, saturating at MAX_WAIT.
  - Clear on ack or when req==0.
- Back-to-back grants: a new grant may occur every cycle, so 100% write-port throughput.
- Same-rd collision: when two sources target the same rd, both writes are performed in grant order; the later write wins in the register file.
- conflict: registered count of pending rd!=0 requests in cycle N is >=2, shown in cycle N+1.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, adds these ports:
  - rs_addr  in  5
  - rt_addr  in  5
  - fwd_rs_hit  out  1
  - fwd_rt_hit  out  1
  - fwd_rs_data  out  32
  - fwd_rt_data  out  32
- fwd_x_hit = we && waddr==x_addr && x_addr!=0, computed combinationally from the registered write port.
- fwd_x_data = wdata when hit, else 0.
- This lets decode bypass a write that lands in the same cycle.
- When undefined: these ports and all forwarding logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: RST=0 for 2 cycles with all req=1 -> all acks 0, we=0, waddr=0, wdata=0, conflict=0. Release -> ld_ack=1 in the first cycle after release.
- Single write: alu_req=1, alu_rd=5, alu_data=0x0000_00AA for 1 cycle -> alu_ack=1 that cycle; next cycle we=1, waddr=5, wdata=0xAA; the cycle after that, we=0.
- Priority and conflict: ld (rd=3, 0x11), alu (rd=4, 0x22) and md (rd=6, 0x33) all asserted together -> grants in order LD, ALU, MD on consecutive cycles; we writes 3, 4, 6 in cycles +1, +2, +3; conflict=1 in cycles +1 and +2.
- Starvation (MAX_WAIT=4): ld_req streams continuously with new rd each cycle while md_req (rd=9, 0x99) is held -> md_ack asserted on the 5th cycle of waiting; ld_ack=0 that cycle; we writes 9 with 0x99 one cycle later.
- Zero register: alu_req with rd=0 together with ld_req rd=7 -> alu_ack=1 and ld_ack=1 in the same cycle; only waddr=7 is written, and no write to 0 ever occurs.
- WB_FWD_EN: after a grant of rd=12 with data 0xDEAD_BEEF, drive rs_addr=12, rt_addr=0 -> fwd_rs_hit=1, fwd_rs_data=0xDEADBEEF, fwd_rt_hit=0, fwd_rt_data=0.
